// File: rtl/vga_pkg.sv
// Default SVGA 800x600@60 Hz raster timing (40 MHz pixel clock) and the
// timing record shared with the downstream vga_out stage.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE_DEF     = 800;
  localparam int H_SYNC_START_DEF = 840;
  localparam int H_SYNC_LEN_DEF   = 128;
  localparam int H_TOTAL_DEF      = 1056;
  localparam int HCOUNT_MAX       = H_TOTAL_DEF - 1;

  localparam int V_ACTIVE_DEF     = 600;
  localparam int V_SYNC_START_DEF = 601;
  localparam int V_SYNC_LEN_DEF   = 4;
  localparam int V_TOTAL_DEF      = 628;
  localparam int VCOUNT_MAX       = V_TOTAL_DEF - 1;

  localparam logic SYNC_POL_DEF   = 1'b1;

  // One raster sample, field for field the same as the generator's outputs.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } vga_timing_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counter for vga_out.
//   clk         in   pixel clock
//   rst_n       in   asynchronous reset, active low
//   en          in   count enable; low freezes the raster
//   hcount      out  current pixel column (11 bit)
//   vcount      out  current line (11 bit)
//   hsync/vsync out  sync pulses, level SYNC_POL when active
//   hblnk/vblnk out  high outside the visible area
//   line_start  out  one-clock strobe on the cycle hcount wrapped to 0
//   frame_start out  one-clock strobe on the cycle (hcount,vcount) wrapped to (0,0)
// All outputs are registered. Flags are computed from the next counter value
// so they line up with the counts shown in the same cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   H_SYNC_START = H_SYNC_START_DEF,
  parameter int   H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int   H_TOTAL      = H_TOTAL_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter int   V_SYNC_START = V_SYNC_START_DEF,
  parameter int   V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter int   V_TOTAL      = V_TOTAL_DEF,
  parameter logic SYNC_POL     = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start
);

  // Totals must fit the 11-bit counters.
  if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL out of range for 11-bit counters");
  end

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);

  // Thresholds carried at 12 bits so an end of range of 2048 still compares.
  localparam logic [CNT_W:0] HA_TH = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_LO = (CNT_W+1)'(H_SYNC_START);
  localparam logic [CNT_W:0] HS_HI = (CNT_W+1)'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [CNT_W:0] VA_TH = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_LO = (CNT_W+1)'(V_SYNC_START);
  localparam logic [CNT_W:0] VS_HI = (CNT_W+1)'(V_SYNC_START + V_SYNC_LEN);

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic [CNT_W:0]   h_nxt_x;
  logic [CNT_W:0]   v_nxt_x;

  always_comb begin
    h_wrap  = (hcount == H_MAX);
    v_wrap  = h_wrap && (vcount == V_MAX);
    h_nxt   = h_wrap ? '0 : CNT_W'(hcount + 1'b1);
    v_nxt   = !h_wrap ? vcount : ((vcount == V_MAX) ? '0 : CNT_W'(vcount + 1'b1));
    h_nxt_x = {1'b0, h_nxt};
    v_nxt_x = {1'b0, v_nxt};
  end

  // Horizontal counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  hcount <= '0;
    else if (en) hcount <= h_nxt;
  end

  // Vertical counter; moves only on a line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            vcount <= '0;
    else if (en && h_wrap) vcount <= v_nxt;
  end

  // Flags follow the next counts. Strobes only fire on a real wrap, so the
  // (0,0) entered from reset is never flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= (h_nxt_x >= HS_LO && h_nxt_x < HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_nxt_x >= VS_LO && v_nxt_x < VS_HI) ? SYNC_POL : ~SYNC_POL;
      hblnk       <= (h_nxt_x >= HA_TH);
      vblnk       <= (v_nxt_x >= VA_TH);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (28x14) so whole frames run
// quickly; a second instance with inverted sync polarity shares the stimulus.
module tb_vga_timing_gen;

  localparam int HA = 16, HSS = 19, HSL = 5, HT = 28;
  localparam int VA = 10, VSS = 11, VSL = 2, VT = 14;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_vs, a_hb, a_vb, a_ls, a_fs;
  logic b_hs, b_vs, b_hb, b_vb, b_ls, b_fs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT),
    .SYNC_POL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .hblnk(a_hb), .vblnk(a_vb),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .hblnk(b_hb), .vblnk(b_vb),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int total = 0;
  int bad   = 0;

  // Reference: number of enabled clocks since reset, and whether the last
  // edge advanced the raster.
  int pos = 0;
  bit adv = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t pos=%0d)", nm, act, exp, $time, pos);
    end
  endtask

  task automatic check_model();
    int h, v;
    bit hs, vs, ls, fs;
    h  = pos % HT;
    v  = (pos / HT) % VT;
    hs = (h >= HSS) && (h < HSS + HSL);
    vs = (v >= VSS) && (v < VSS + VSL);
    ls = adv && (h == 0);
    fs = adv && (pos % FR == 0);
    chk("hcount", int'(a_h), h);
    chk("vcount", int'(a_v), v);
    chk("hsync", int'(a_hs), int'(hs));
    chk("vsync", int'(a_vs), int'(vs));
    chk("hblnk", int'(a_hb), int'(h >= HA));
    chk("vblnk", int'(a_vb), int'(v >= VA));
    chk("line_start", int'(a_ls), int'(ls));
    chk("frame_start", int'(a_fs), int'(fs));
    chk("neg_hcount", int'(b_h), h);
    chk("neg_vcount", int'(b_v), v);
    chk("neg_hsync", int'(b_hs), int'(!hs));
    chk("neg_vsync", int'(b_vs), int'(!vs));
    chk("neg_strobes", int'({b_ls, b_fs}), int'({ls, fs}));
  endtask

  // One clock with the given enable; outputs compared on the falling edge.
  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    if (rst_n) begin
      adv = e;
      if (e) pos++;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hcount"}, int'(a_h), 0);
    chk({tag, "_vcount"}, int'(a_v), 0);
    chk({tag, "_hsync"}, int'(a_hs), 0);
    chk({tag, "_vsync"}, int'(a_vs), 0);
    chk({tag, "_neg_sync"}, int'({b_hs, b_vs}), 3);
    chk({tag, "_blank"}, int'({a_hb, a_vb}), 0);
    chk({tag, "_strobes"}, int'({a_ls, a_fs}), 0);
  endtask

  typedef struct {
    logic e;
    int   n;
    int   h;
    int   v;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nfs, nls, first_fs, last_fs, gap_bad;

    vecs[0] = '{1'b1, 1,   1,  0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 26,  27, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1,   0,  1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 5,   0,  1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1,   1,  1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 362, 27, 13, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1,   0,  0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1,   1,  0, 1'b0, 1'b0};

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed rows from reset release, including a wrap, a freeze on a
    // wrap cycle and the first frame wrap.
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].e);
      chk($sformatf("vec%0d_h", i), int'(a_h), vecs[i].h);
      chk($sformatf("vec%0d_v", i), int'(a_v), vecs[i].v);
      chk($sformatf("vec%0d_ls", i), int'(a_ls), int'(vecs[i].ls));
      chk($sformatf("vec%0d_fs", i), int'(a_fs), int'(vecs[i].fs));
    end

    // Freeze mid-line: outputs hold, and counting resumes at the next value.
    while (!(a_h == 11'd10 && a_v == 11'd5)) tick(1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0);
    chk("freeze_h", int'(a_h), 10);
    chk("freeze_v", int'(a_v), 5);
    tick(1'b1);
    chk("resume_h", int'(a_h), 11);

    // Random enable pattern against the reference.
    for (int k = 0; k < 2000; k++) tick(logic'($urandom_range(0, 3) != 0));

    // Async reset mid-frame: outputs clear before the next clock edge.
    while (a_v != 11'd7) tick(1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    pos = 0;
    adv = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_model();

    // Three frames after release: strobe counts and spacing.
    nfs = 0; nls = 0; first_fs = -1; last_fs = -1; gap_bad = 0;
    for (int k = 1; k <= 3 * FR; k++) begin
      tick(1'b1);
      if (a_ls) nls++;
      if (a_fs) begin
        nfs++;
        if (first_fs < 0) first_fs = k;
        else if (k - last_fs != FR) gap_bad++;
        last_fs = k;
      end
    end
    chk("frame_count", nfs, 3);
    chk("line_count", nls, 3 * VT);
    chk("first_frame_at", first_fs, FR);
    chk("frame_gap_errs", gap_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
